// File: rtl/spi_kb_pkg.sv
// spi_kb_pkg: shared ZX keyboard matrix constants, FSM states and bit mapping.
package spi_kb_pkg;
  localparam int KB_FRAME_BITS = 40;
  localparam int KB_LINES = 5;
  localparam int KB_ROWS = 8;
  typedef enum logic [2:0] {IDLE, LEAD, HIGH, LOW, TAIL, GAP} kb_state_e;
  // Line 0 row 0 is the first bit on the wire.
  function automatic int kb_bit_index(input int line, input int row);
    return KB_FRAME_BITS - 1 - KB_ROWS * line - row;
  endfunction
endpackage

// File: rtl/kb5x8_spi_tx_if.sv
// kb5x8_spi_tx_if: request side (matrix + strobe) and SPI side of the keyboard sender.
interface kb5x8_spi_tx_if;
  logic [spi_kb_pkg::KB_FRAME_BITS-1:0] KEYS;
  logic START;
  logic BUSY;
  logic DONE;
  logic SPI_CLK;
  logic SPI_CS;
  logic SPI_MOSI;
  modport master (output KEYS, START, input BUSY, DONE, SPI_CLK, SPI_CS, SPI_MOSI);
  modport slave (input KEYS, START, output BUSY, DONE, SPI_CLK, SPI_CS, SPI_MOSI);
endinterface

// File: rtl/kb_spi_phase_div.sv
// kb_spi_phase_div: counts len cycles per FSM phase and strobes phase_end on the last one.
module kb_spi_phase_div #(
  parameter int W = 4
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         restart,
  input  logic [W-1:0] len,
  output logic         phase_end
);
  logic [W-1:0] cnt;
  assign phase_end = !restart && cnt == len - W'(1);
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) cnt <= '0;
    else cnt <= (restart || phase_end) ? '0 : cnt + W'(1);
  end
endmodule

// File: rtl/kb5x8_spi_tx.sv
// kb5x8_spi_tx: SPI master sending a 40-bit keyboard matrix frame, with one queued request.
module kb5x8_spi_tx
  import spi_kb_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int GAP_CYCLES = 8,
  parameter int FRAME_BITS = KB_FRAME_BITS
) (
  input logic CLK,
  input logic RST_N,
  kb5x8_spi_tx_if.slave bus
);
  localparam int MAXC = CLK_DIV > GAP_CYCLES ? CLK_DIV : GAP_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam int BW = $clog2(FRAME_BITS + 1);
  kb_state_e state, state_nx;
  logic [FRAME_BITS-1:0] sh, pdata;
  logic [BW-1:0] bitcnt;
  logic pend, pe, launch, last;
  logic cs_q, sck_q, busy_q, done_q;
  logic cs_d, sck_d, busy_d, done_d;
  assign launch = bus.START || pend;
  assign last = bitcnt == BW'(FRAME_BITS);
  kb_spi_phase_div #(.W(CW)) u_div (
    .CLK(CLK),
    .RST_N(RST_N),
    .restart(state == IDLE),
    .len(state == GAP ? CW'(GAP_CYCLES) : CW'(CLK_DIV)),
    .phase_end(pe)
  );
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = launch ? LEAD : IDLE;
      LEAD: state_nx = pe ? HIGH : LEAD;
      HIGH: state_nx = pe ? LOW : HIGH;
      LOW:  state_nx = pe ? (last ? TAIL : HIGH) : LOW;
      TAIL: state_nx = pe ? GAP : TAIL;
      GAP:  state_nx = pe ? IDLE : GAP;
      default: state_nx = IDLE;
    endcase
  end
  // Outputs are decoded from the next state so the pins switch with the state register.
  always_comb begin
    cs_d = state_nx == IDLE || state_nx == GAP;
    sck_d = state_nx == HIGH;
    busy_d = state_nx != IDLE;
    done_d = state == TAIL && state_nx == GAP;
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cs_q <= 1'b1;
      sck_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sh <= '0;
      bitcnt <= '0;
      pend <= 1'b0;
      pdata <= '0;
    end else begin
      cs_q <= cs_d;
      sck_q <= sck_d;
      busy_q <= busy_d;
      done_q <= done_d;
      if (state == IDLE && launch) begin
        sh <= bus.START ? bus.KEYS : pdata;
        bitcnt <= '0;
      end else if (pe && state == HIGH) begin
        bitcnt <= bitcnt + BW'(1);
      end else if (pe && state == LOW && !last) begin
        sh <= sh << 1;
      end else if (pe && state == TAIL) begin
        sh <= '0;
      end
      // A request arriving outside IDLE is held; the newest matrix overwrites older ones.
      pend <= state == IDLE ? 1'b0 : pend || bus.START;
      if (state != IDLE && bus.START) pdata <= bus.KEYS;
    end
  end
  assign bus.SPI_CS = cs_q;
  assign bus.SPI_CLK = sck_q;
  assign bus.SPI_MOSI = sh[FRAME_BITS-1];
  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;
endmodule

// File: tb/tb_kb5x8_spi_tx.sv
// tb_kb5x8_spi_tx: directed vectors plus multi-cycle sequences against a behavioural receiver.
module tb_kb5x8_spi_tx;
  import spi_kb_pkg::*;
  localparam int DIV = 4;
  localparam int GAPC = 8;
  localparam int LOW_CYC = 328;
  localparam int GAP_SEEN = 9;
  typedef struct {
    logic [39:0] keys;
    logic [39:0] exp_rx;
    int exp_low;
    int exp_edges;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  kb5x8_spi_tx_if bus();
  kb5x8_spi_tx #(.CLK_DIV(DIV), .GAP_CYCLES(GAPC)) dut (
    .CLK(clk),
    .RST_N(rst_n),
    .bus(bus.slave)
  );
  logic [39:0] rx = '0;
  int falls = 0, fr_falls = 0, low_run = 0, high_run = 0, done_cnt = 0, viol = 0;
  logic [39:0] frames[$];
  int lows[$], fr_edges[$], gaps[$];
  int tests = 0, fails = 0;
  vec_t vecs[5];
  always @(negedge bus.SPI_CLK) if (rst_n) begin
    rx <= {rx[38:0], bus.SPI_MOSI};
    falls++;
    fr_falls++;
  end
  always @(negedge bus.SPI_CS) if (rst_n) begin
    gaps.push_back(high_run);
    low_run = 0;
    fr_falls = 0;
  end
  always @(posedge bus.SPI_CS) if (rst_n) begin
    frames.push_back(rx);
    lows.push_back(low_run);
    fr_edges.push_back(fr_falls);
    high_run = 0;
  end
  always @(negedge clk) if (rst_n) begin
    if (bus.SPI_CS) high_run++;
    else low_run++;
    if (bus.DONE) done_cnt++;
    if (bus.SPI_CS && bus.SPI_CLK) viol++;
  end
  always @(bus.SPI_CLK) if (rst_n && bus.SPI_CS) viol++;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic pulse(input logic [39:0] k);
    @(negedge clk);
    bus.KEYS = k;
    bus.START = 1'b1;
    @(negedge clk);
    bus.START = 1'b0;
  endtask
  task automatic wait_frames(input int n, input string name);
    for (int i = 0; i < 3000; i++) begin
      if (frames.size() >= n) return;
      @(negedge clk);
    end
    tests++;
    fails++;
    $display("FAIL %s: timeout with %0d frames, expected %0d", name, frames.size(), n);
  endtask
  task automatic idle_wait(input string name);
    int quiet = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      quiet = bus.BUSY ? 0 : quiet + 1;
      if (quiet >= 20) return;
    end
    tests++;
    fails++;
    $display("FAIL %s: BUSY never settled low", name);
  endtask
  task automatic clear_log;
    frames.delete();
    lows.delete();
    fr_edges.delete();
    gaps.delete();
    done_cnt = 0;
  endtask
  function automatic logic [4:0] kl_model(input logic [39:0] m, input logic [7:0] ba);
    logic [4:0] kl = 5'b11111;
    for (int k = 0; k < 5; k++)
      for (int r = 0; r < 8; r++)
        if (!ba[r] && m[39 - 8 * k - r]) kl[k] = 1'b0;
    return kl;
  endfunction
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int base;
    logic [7:0] ba;
    vecs[0] = '{40'h80_0000_0001, 40'h80_0000_0001, LOW_CYC, 40};
    vecs[1] = '{40'h00_0000_0000, 40'h00_0000_0000, LOW_CYC, 40};
    vecs[2] = '{40'hFF_FFFF_FFFF, 40'hFF_FFFF_FFFF, LOW_CYC, 40};
    vecs[3] = '{40'h12_3456_789A, 40'h12_3456_789A, LOW_CYC, 40};
    vecs[4] = '{40'h5A_C3E1_0F96, 40'h5A_C3E1_0F96, LOW_CYC, 40};
    bus.KEYS = '0;
    bus.START = 1'b0;
    repeat (6) begin
      @(negedge clk);
      bus.KEYS = 40'({$urandom(), $urandom()});
      bus.START = 1'($urandom());
    end
    chk("reset_cs", 64'(bus.SPI_CS), 64'd1);
    chk("reset_sck", 64'(bus.SPI_CLK), 64'd0);
    chk("reset_mosi", 64'(bus.SPI_MOSI), 64'd0);
    chk("reset_busy", 64'(bus.BUSY), 64'd0);
    chk("reset_done", 64'(bus.DONE), 64'd0);
    bus.START = 1'b0;
    bus.KEYS = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("release_no_sck", 64'(falls), 64'd0);
    chk("release_busy", 64'(bus.BUSY), 64'd0);
    foreach (vecs[i]) begin
      clear_log();
      pulse(vecs[i].keys);
      wait_frames(1, "vec_frame");
      idle_wait("vec_idle");
      if (frames.size() > 0) begin
        chk($sformatf("vec%0d_data", i), 64'(frames[0]), 64'(vecs[i].exp_rx));
        chk($sformatf("vec%0d_cs_low", i), 64'(lows[0]), 64'(vecs[i].exp_low));
        chk($sformatf("vec%0d_edges", i), 64'(fr_edges[0]), 64'(vecs[i].exp_edges));
      end
      chk($sformatf("vec%0d_done", i), 64'(done_cnt), 64'd1);
    end
    clear_log();
    pulse(40'hAA_AAAA_AAAA);
    repeat (60) @(negedge clk);
    pulse(40'h11_2233_4455);
    repeat (60) @(negedge clk);
    pulse(40'h0F_0F0F_0F0F);
    wait_frames(2, "pend_frames");
    idle_wait("pend_idle");
    repeat (400) @(negedge clk);
    chk("pend_count", 64'(frames.size()), 64'd2);
    chk("pend_done", 64'(done_cnt), 64'd2);
    if (frames.size() >= 2) begin
      chk("pend_first", 64'(frames[0]), 64'h00_AA_AAAA_AAAA);
      chk("pend_second", 64'(frames[1]), 64'h00_0F_0F0F_0F0F);
      chk("pend_gap", 64'(gaps[1]), 64'(GAP_SEEN));
    end
    clear_log();
    viol = 0;
    @(negedge clk);
    bus.KEYS = 40'hFF_FFFF_FFFF;
    bus.START = 1'b1;
    wait_frames(3, "cont_frames");
    bus.START = 1'b0;
    idle_wait("cont_idle");
    if (frames.size() >= 3) begin
      for (int i = 0; i < 3; i++)
        chk($sformatf("cont%0d_data", i), 64'(frames[i]), 64'h00_FF_FFFF_FFFF);
      chk("cont_gap1", 64'(gaps[1]), 64'(GAP_SEEN));
      chk("cont_gap2", 64'(gaps[2]), 64'(GAP_SEEN));
      chk("cont_low1", 64'(lows[1]), 64'(LOW_CYC));
    end
    chk("cont_sck_cs_high", 64'(viol), 64'd0);
    clear_log();
    pulse(40'hC3_5A96_E17B);
    repeat (20) @(negedge clk);
    pulse(40'h55_5555_5555);
    for (int i = 0; i < 2000 && fr_falls < 17; i++) @(negedge clk);
    chk("rst_mid_reached17", 64'(fr_falls >= 17), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_cs", 64'(bus.SPI_CS), 64'd1);
    chk("rst_mid_sck", 64'(bus.SPI_CLK), 64'd0);
    chk("rst_mid_busy", 64'(bus.BUSY), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    base = falls;
    repeat (500) @(negedge clk);
    chk("rst_mid_no_queue", 64'(frames.size()), 64'd0);
    chk("rst_mid_no_sck", 64'(falls - base), 64'd0);
    pulse(40'h12_3456_789A);
    wait_frames(1, "rst_after_frame");
    idle_wait("rst_after_idle");
    if (frames.size() > 0) chk("rst_after_data", 64'(frames[0]), 64'h00_12_3456_789A);
    clear_log();
    pulse(40'h00_0004_0000);
    wait_frames(1, "map_frame");
    idle_wait("map_idle");
    chk("map_index", 64'(kb_bit_index(2, 5)), 64'd18);
    if (frames.size() > 0)
      for (int r = 0; r < 8; r++) begin
        ba = ~(8'd1 << r);
        chk($sformatf("map_ba_%02h", ba), 64'(kl_model(frames[0], ba)),
            r == 5 ? 64'b11011 : 64'b11111);
      end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
